// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two byte-enabled write ports, busy-alloc port,
// and NUM_RD flattened read ports with registered responses.
interface reg_file_mp_if #(
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 32,
  parameter int NUM_RD = 2
);
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [WIDTH-1:0]         wdata0;
  logic [WIDTH/8-1:0]       wbe0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [WIDTH-1:0]         wdata1;
  logic [WIDTH/8-1:0]       wbe1;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*WIDTH-1:0]  rdata;
  logic [NUM_RD-1:0]        rvalid;
  logic [NUM_RD-1:0]        rbusy;

  modport master (
    output we0, waddr0, wdata0, wbe0,
    output we1, waddr1, wdata1, wbe1,
    output alloc_en, alloc_addr, re, raddr,
    input  rdata, rvalid, rbusy
  );

  modport slave (
    input  we0, waddr0, wdata0, wbe0,
    input  we1, waddr1, wdata1, wbe1,
    input  alloc_en, alloc_addr, re, raddr,
    output rdata, rvalid, rbusy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-first forwarding and a per-register busy
// scoreboard. Define REG_FILE_MP_ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_mp #(
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int NB   = WIDTH / 8;
  localparam int NREG = 2 ** ADDR_W;

  // Post-edge view of every address; holes beyond DEPTH read as zero/not busy.
  logic [WIDTH-1:0] rd_view [NREG];
  logic [NREG-1:0]  busy_view;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi < DEPTH) begin : g_live
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
`ifdef REG_FILE_MP_ZERO_REG_EN
        localparam bit WRITABLE = (gi != 0);
`else
        localparam bit WRITABLE = 1'b1;
`endif
        logic [WIDTH-1:0] word_reg;
        logic [WIDTH-1:0] word_next;
        logic             busy_reg;
        logic             busy_next;
        logic             hit0;
        logic             hit1;
        logic             alloc_hit;
        logic             wr_any;

        assign hit0      = WRITABLE && bus.we0 && (bus.waddr0 == IDX);
        assign hit1      = WRITABLE && bus.we1 && (bus.waddr1 == IDX);
        assign alloc_hit = WRITABLE && bus.alloc_en && (bus.alloc_addr == IDX);
        assign wr_any    = (hit0 && (|bus.wbe0)) || (hit1 && (|bus.wbe1));

        // Port 1 owns any byte it enables; port 0 fills the rest.
        always_comb begin
          word_next = word_reg;
          for (int b = 0; b < NB; b++) begin
            if (hit1 && bus.wbe1[b])
              word_next[b*8 +: 8] = bus.wdata1[b*8 +: 8];
            else if (hit0 && bus.wbe0[b])
              word_next[b*8 +: 8] = bus.wdata0[b*8 +: 8];
          end
        end

        // A fresh alloc supersedes a writeback completing on the same edge.
        assign busy_next = alloc_hit ? 1'b1 : (wr_any ? 1'b0 : busy_reg);

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            word_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            word_reg <= word_next;
            busy_reg <= busy_next;
          end
        end

        assign rd_view[gi]   = word_next;
        assign busy_view[gi] = busy_next;
      end else begin : g_hole
        assign rd_view[gi]   = '0;
        assign busy_view[gi] = 1'b0;
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  rdata_reg;
      logic              rvalid_reg;
      logic              rbusy_reg;

      assign addr = bus.raddr[gi*ADDR_W +: ADDR_W];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
          rbusy_reg  <= 1'b0;
        end else begin
          rvalid_reg <= bus.re[gi];
          if (bus.re[gi]) begin
            rdata_reg <= rd_view[addr];
            rbusy_reg <= busy_view[addr];
          end
        end
      end

      assign bus.rdata[gi*WIDTH +: WIDTH] = rdata_reg;
      assign bus.rvalid[gi]               = rvalid_reg;
      assign bus.rbusy[gi]                = rbusy_reg;
    end
  endgenerate
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the CPU/cache datapath.
- Supports NUM_RD registered read ports and two prioritised write ports with byte enables.
- Forwards same-cycle writes to reads (write-first).
- Includes a per-register busy scoreboard so the issue/cache-controller logic can track outstanding writebacks.

Parameters:
- ADDR_W, 5, register address width.
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; DEPTH <= 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- we0  in  1  write port 0 enable.
- waddr0  in  ADDR_W  write port 0 address.
- wdata0  in  WIDTH  write port 0 data.
- wbe0  in  WIDTH/8  write port 0 byte enables.
- we1  in  1  write port 1 enable (higher priority).
- waddr1  in  ADDR_W  write port 1 address.
- wdata1  in  WIDTH  write port 1 data.
- wbe1  in  WIDTH/8  write port 1 byte enables.
- alloc_en  in  1  mark a register busy (pending write).
- alloc_addr  in  ADDR_W  register to mark busy.
- re  in  NUM_RD  per-port read request.
- raddr  in  NUM_RD*ADDR_W  flattened read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*WIDTH  flattened registered read data.
- rvalid  out  NUM_RD  rdata[k] is valid this cycle.
- rbusy  out  NUM_RD  busy bit of the register read by port k, registered with rdata.

Behaviour:
- Reset (rst=0, asynchronous): all DEPTH registers = 0; all busy bits = 0; rdata = 0; rvalid = 0; rbusy = 0. Reset asserted mid-operation discards any in-flight read (rvalid=0 in the next cycle) and any same-edge write.
- Write: on a rising edge with weX=1 and waddrX<DEPTH, byte b of mem[waddrX] takes wdataX byte b where wbeX[b]=1; other bytes hold. weX=1 with wbeX=0 changes nothing.
- Out-of-range addresses (>=DEPTH): writes and allocs are ignored; reads return 0 with rvalid=1 and rbusy=0.
- Same address on both write ports in one cycle: resolved per byte, port 1 wins where both enables are set, port 0 bytes are kept elsewhere.
- Read latency is exactly 1 cycle. If re[k]=1 at edge N, then in cycle N+1 rvalid[k]=1, and rdata[k] = mem[raddr[k]] after applying both edge-N writes (write-first forwarding with the per-byte merge above). rbusy[k] = busy bit after edge-N updates.
- If re[k]=0: rvalid[k]=0 next cycle; rdata[k] and rbusy[k] hold their previous values.
- Ports are independent; any number may read the same address.
- Scoreboard:
  - alloc_en sets busy[alloc_addr].
  - Any write (we0 or we1 with a nonzero byte enable) clears busy[waddr].
  - Alloc and write to the same register on the same edge leave busy=1 (alloc wins: a new pending write supersedes the one completing).
- No internal state machine beyond storage and the per-port output registers. All outputs are driven from flops (no combinational path from inputs to outputs).

Optional Feature:
- Macro: REG_FILE_MP_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are ignored, including forwarding.
  - alloc to address 0 is ignored.
  - Reads of address 0 return 0 with rbusy=0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then read: assert rst=0 for 2 cycles, release, re=2'b11, raddr={5'd7,5'd3} -> next cycle rvalid=2'b11, both rdata=0, rbusy=0.
- Byte-enable write: we0=1, waddr0=4, wdata0=32'hAABBCCDD, wbe0=4'b1111; next cycle we0=1, wdata0=32'h11223344, wbe0=4'b0101 -> read of reg 4 returns 32'hAA22CC44.
- Dual write collision plus forwarding, same edge:
  - Stimulus: we0 to reg 9 with 32'h0000FFFF, wbe0=4'b1111; we1 to reg 9 with 32'h12345678, wbe1=4'b1100; re[0]=1, raddr 9.
  - Response: rdata[0]=32'h1234FFFF in the next cycle.
- Scoreboard:
  - alloc reg 5 -> read 5 gives rbusy=1.
  - Write reg 5 with wbe=4'b0001 -> rbusy=0.
  - Alloc and write reg 5 on the same edge -> rbusy=1.
- Reset mid-operation: re=1 at edge N, rst asserted before edge N+1 -> rvalid=0, rdata=0 until reset release. Previously written reg 4 reads back 0.
- Optional feature, with REG_FILE_MP_ZERO_REG_EN defined:
  - Write 32'hDEADBEEF to reg 0 plus alloc reg 0 -> read returns 0, rbusy=0.
  - Without the macro -> read returns 32'hDEADBEEF, rbusy=1.
